// File: rtl/sink_in_1bit_s.sv
// Serial 1-bit stream receiver: deserializes MSB-first into WIDTH-bit words with a valid/ready output.
// Define SINK_IN_PARITY_EN to expect a trailing even-parity bit after every word.
module sink_in_1bit_s #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_en_in,
  input  logic             data_in,
  input  logic             out_ready,
  input  logic             clr_status,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_err,
  output logic             overflow,
  output logic             parity_err,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef SINK_IN_PARITY_EN
  localparam int unsigned BPW  = WIDTH + 1;
  localparam int unsigned SH_W = WIDTH;
`else
  localparam int unsigned BPW  = WIDTH;
  localparam int unsigned SH_W = WIDTH - 1;
`endif
  localparam int unsigned BC_W = $clog2(BPW);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t           r_state;
  logic             r_en;
  logic             r_d;
  logic [SH_W-1:0]  r_shreg;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_frame_start;
  logic             r_frame_end;
  logic             r_frame_err;
  logic             r_overflow;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_word_done;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;

  assign w_word_done = r_en && (r_bit_cnt == BC_W'(BPW - 1));
  assign w_drop      = w_word_done && r_out_valid && !out_ready;

`ifdef SINK_IN_PARITY_EN
  // Current bit is the parity bit; the data bits are already in the shift register.
  logic r_parity_err;
  logic w_par_bad;
  assign w_word     = r_shreg;
  assign w_par_bad  = ^{r_shreg, r_d};
  assign parity_err = r_parity_err;
`else
  assign w_word     = {r_shreg, r_d};
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_en          <= 1'b0;
      r_d           <= 1'b0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_cnt   <= '0;
`ifdef SINK_IN_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_en          <= data_en_in;
      r_d           <= data_in;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_err   <= 1'b0;
`ifdef SINK_IN_PARITY_EN
      r_parity_err  <= 1'b0;
`endif

      if (r_frame_end) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (r_en) begin
            r_state       <= S_RECV;
            r_frame_start <= 1'b1;
          end
        end
        S_RECV: begin
          if (!r_en) begin
            r_state     <= S_IDLE;
            r_frame_end <= 1'b1;
            r_frame_err <= (r_bit_cnt != '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Partial bits are discarded whenever the enable drops.
      if (r_en) begin
        r_shreg   <= SH_W'({r_shreg, r_d});
        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BC_W'(1);
      end else begin
        r_bit_cnt <= '0;
      end

      if (w_word_done && !w_drop) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_word;
`ifdef SINK_IN_PARITY_EN
        r_parity_err <= w_par_bad;
`endif
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A drop wins over a simultaneous clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_status) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: doc/sink_in_1bit_s.md
# sink_in_1bit_s

Single-clock serial receiver for the 1-bit source stream: it samples the enable-qualified serial bit line (data_en/data_out pair driven by the 1-bit source block), deserializes MSB-first into WIDTH-bit words, and hands them out over a valid/ready interface. It tracks frame boundaries (enable high = frame), flags truncated frames and dropped words, and counts frames. It sits at the receive end of the controller's 1-bit data path, ahead of word-wide consumers.

## Interface
- WIDTH, 8, data bits per word (>= 2)
- CNT_W, 16, frame counter width
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- data_en_in  in  1  serial enable; high = bit valid, frame in progress
- data_in  in  1  serial data bit
- out_ready  in  1  downstream ready
- clr_status  in  1  clears sticky overflow
- out_data  out  WIDTH  received word, first bit received in MSB
- out_valid  out  1  out_data valid
- frame_start  out  1  one-cycle pulse, frame begins
- frame_end  out  1  one-cycle pulse, frame ends
- frame_err  out  1  one-cycle pulse, frame ended with a partial word
- overflow  out  1  sticky; a completed word was dropped
- parity_err  out  1  one-cycle pulse; 0 unless SINK_IN_PARITY_EN
- frame_cnt  out  CNT_W  completed frames, wraps

## Operation
- Input stage: en_r <= data_en_in, d_r <= data_in every cycle; all logic below uses en_r/d_r only.
- FSM states IDLE, RECV.
  - IDLE -> RECV when en_r=1; frame_start=1 that cycle; that cycle's bit is accepted.
  - RECV -> IDLE when en_r=0; frame_end=1 that cycle; frame_cnt += 1 (mod 2^CNT_W). If bit_cnt != 0, frame_err=1 and partial bits are discarded; bit_cnt <= 0.
  - Back-to-back frames need at least one en_r=0 cycle; no gap = one frame.
- Bit accept (en_r=1): shreg <= {shreg[WIDTH-2:0], d_r}; bit_cnt += 1. On the last bit of a word (bit_cnt = WIDTH-1, or the parity bit with macro), out_data is loaded with the complete word (including the current bit), bit_cnt <= 0.
- Output handshake: transfer when out_valid & out_ready; out_valid clears after transfer unless a new word loads the same cycle.
  - Word completes while out_valid=1 and out_ready=0: new word dropped, out_data unchanged, overflow <= 1.
  - Word completes while out_valid=1 and out_ready=1: old word transfers, new word loads, out_valid stays 1, no overflow.
  - overflow cleared only by rst or clr_status; clr_status and a simultaneous drop -> overflow stays 1.
- Reset: all outputs 0, shreg/bit_cnt/frame_cnt 0, en_r/d_r 0, state IDLE. Reset mid-frame abandons it with no frame_end; if data_en_in is still high after release, a new frame_start is generated and bits are counted from there.

## Timing
- Bit on data_in sampled at edge k -> shifted at edge k+1. If it completes a word, out_valid=1 after edge k+1 (2-cycle latency).
- data_en_in rising at edge k -> frame_start high in the cycle after edge k+1. Falling at edge k -> frame_end/frame_err high in the cycle after edge k+1; frame_cnt updated after edge k+2.
- Sustained throughput: one bit per cycle, one word per WIDTH cycles (WIDTH+1 with parity).
- Pulses frame_start/frame_end/frame_err/parity_err last exactly one cycle.

## Configuration
- SINK_IN_PARITY_EN defined: each word is WIDTH data bits followed by one even-parity bit (XOR of data plus parity = 0). The parity bit is not stored; parity_err pulses in the cycle out_valid is loaded with a word whose parity fails; the word is still delivered. A frame ending after data but before parity counts as partial (frame_err).
- Not defined: words are WIDTH bits, no parity logic, parity_err tied 0.

## Test plan
- WIDTH=8, one frame of bits 1,0,1,0,0,1,0,1 with out_ready=1 -> out_data=0xA5, out_valid for 1 cycle, 2 cycles after last bit; frame_start, frame_end, frame_cnt=1, frame_err=0.
- 20-bit frame (0xA5, 0x3C, then 4 bits) -> two words delivered, frame_err pulse at frame_end, frame_cnt=1.
- out_ready=0, frame with 0xA5 then 0x3C -> out_data holds 0xA5, overflow=1; clr_status -> overflow=0.
- out_ready asserted exactly in the load cycle of the second word -> 0xA5 transfers, 0x3C loads, out_valid stays high, overflow=0.
- rst asserted mid-word with data_en_in high -> all outputs 0, no frame_end; after release a new frame_start and aligned counting from the next bit.
- SINK_IN_PARITY_EN, word 0xA5 with parity bit 1 -> out_data=0xA5, parity_err pulse; with parity bit 0 -> no pulse.
